// File: rtl/jtag_test_data_register_if.sv
// Signal bundle between the TAP controller (master) and one test data register (slave).
// Carries the decoded DR enables, serial data and the parallel capture/update buses.
// The register length is a parameter; shift_count is sized to hold 0..WIDTH.
interface jtag_test_data_register_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic             select;
    logic             captureDR;
    logic             shiftDR;
    logic             updateDR;
    logic             tdi;
    logic             tdo;
    logic [WIDTH-1:0] capture_in;
    logic [WIDTH-1:0] update_out;
    logic             update_valid;
    logic             update_err;
    logic [CW-1:0]    shift_count;

    // TAP side: drives enables and serial/parallel inputs, observes the register.
    modport master (
        output select,
        output captureDR,
        output shiftDR,
        output updateDR,
        output tdi,
        output capture_in,
        input  tdo,
        input  update_out,
        input  update_valid,
        input  update_err,
        input  shift_count
    );

    // Register side.
    modport slave (
        input  select,
        input  captureDR,
        input  shiftDR,
        input  updateDR,
        input  tdi,
        input  capture_in,
        output tdo,
        output update_out,
        output update_valid,
        output update_err,
        output shift_count
    );
endinterface

// File: rtl/jtag_test_data_register.sv
// Generic IEEE 1149.1 test data register: capture, LSB-first serial shift and a
// parallel update stage with a one-cycle commit strobe.
// Optional feature macro: JTAG_TDR_LENGTH_CHECK_EN
//   defined   - update commits only when exactly WIDTH (saturated) bits were shifted;
//               otherwise update_out holds and a sticky update_err is raised.
//   undefined - update always commits and update_err is tied low.
module jtag_test_data_register #(
    parameter int unsigned      WIDTH         = 32,
    parameter bit               CAPTURE_CONST = 1'b0,
    parameter logic [WIDTH-1:0] CAPTURE_VALUE = '0,
    parameter bit               FORCE_LSB1    = 1'b0,
    parameter logic [WIDTH-1:0] UPDATE_RESET  = '0
) (
    input logic                        tck,
    input logic                        trst,
    jtag_test_data_register_if.slave   tdr
);

    localparam int unsigned   CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CountMax = CW'(WIDTH);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] upd_q, upd_d;
    logic [CW-1:0]    count_q, count_d;
    logic             valid_q, valid_d;
`ifdef JTAG_TDR_LENGTH_CHECK_EN
    logic             err_q, err_d;
`endif

    // Next-state decode; priority is capture > shift > update, all gated by select.
    always_comb begin
        shift_d = shift_q;
        upd_d   = upd_q;
        count_d = count_q;
        valid_d = 1'b0;
`ifdef JTAG_TDR_LENGTH_CHECK_EN
        err_d   = err_q;
`endif
        if (tdr.select) begin
            if (tdr.captureDR) begin
                shift_d = CAPTURE_CONST ? CAPTURE_VALUE : tdr.capture_in;
                if (FORCE_LSB1) begin
                    shift_d[0] = 1'b1;
                end
                count_d = '0;
`ifdef JTAG_TDR_LENGTH_CHECK_EN
                err_d   = 1'b0;
`endif
            end else if (tdr.shiftDR) begin
                // Shift right and insert tdi at the MSB; also correct for WIDTH == 1.
                shift_d             = shift_q >> 1;
                shift_d[WIDTH-1]    = tdr.tdi;
                if (count_q != CountMax) begin
                    count_d = count_q + 1'b1;
                end
            end else if (tdr.updateDR) begin
`ifdef JTAG_TDR_LENGTH_CHECK_EN
                // Count saturates at WIDTH, so over-length scans still commit.
                if (count_q == CountMax) begin
                    upd_d   = shift_q;
                    valid_d = 1'b1;
                end else begin
                    err_d   = 1'b1;
                end
`else
                upd_d   = shift_q;
                valid_d = 1'b1;
`endif
            end
        end
    end

    // Register state; trst clears everything immediately so no partial update survives.
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            shift_q <= '0;
            upd_q   <= UPDATE_RESET;
            count_q <= '0;
            valid_q <= 1'b0;
`ifdef JTAG_TDR_LENGTH_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            shift_q <= shift_d;
            upd_q   <= upd_d;
            count_q <= count_d;
            valid_q <= valid_d;
`ifdef JTAG_TDR_LENGTH_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // tdo is combinational from the LSB; the TAP retimes it onto the falling edge.
    assign tdr.tdo          = shift_q[0];
    assign tdr.update_out   = upd_q;
    assign tdr.update_valid = valid_q;
    assign tdr.shift_count  = count_q;
`ifdef JTAG_TDR_LENGTH_CHECK_EN
    assign tdr.update_err   = err_q;
`else
    assign tdr.update_err   = 1'b0;
`endif

endmodule

// File: tb/tb_jtag_test_data_register.sv
// Directed bench for jtag_test_data_register: an 8-bit capture_in instance and a
// 32-bit IDCODE-style instance share tck/trst.
module tb_jtag_test_data_register;

    logic tck;
    logic trst;

    int unsigned n_total;
    int unsigned n_bad;

    jtag_test_data_register_if #(.WIDTH(8))  a_if ();
    jtag_test_data_register_if #(.WIDTH(32)) b_if ();

    jtag_test_data_register #(
        .WIDTH        (8),
        .CAPTURE_CONST(1'b0),
        .CAPTURE_VALUE(8'h00),
        .FORCE_LSB1   (1'b0),
        .UPDATE_RESET (8'h5A)
    ) u_a (
        .tck (tck),
        .trst(trst),
        .tdr (a_if.slave)
    );

    jtag_test_data_register #(
        .WIDTH        (32),
        .CAPTURE_CONST(1'b1),
        .CAPTURE_VALUE(32'h1234_5678),
        .FORCE_LSB1   (1'b1),
        .UPDATE_RESET (32'h0000_0000)
    ) u_b (
        .tck (tck),
        .trst(trst),
        .tdr (b_if.slave)
    );

    initial begin
        tck = 1'b0;
        forever #5 tck = ~tck;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One edge; inputs change and outputs are sampled 1 time unit after posedge.
    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    // Drive enables on instance A for one edge, then drop them.
    task automatic a_op(input logic cap, input logic sh, input logic upd, input logic d);
        a_if.captureDR = cap;
        a_if.shiftDR   = sh;
        a_if.updateDR  = upd;
        a_if.tdi       = d;
        tick();
        a_if.captureDR = 1'b0;
        a_if.shiftDR   = 1'b0;
        a_if.updateDR  = 1'b0;
    endtask

    logic [7:0]  got8;
    logic [7:0]  pat8;
    logic [11:0] pat12;
    logic [31:0] got32;
    logic [7:0]  exp_upd;
    logic        exp_valid;
    logic        exp_err;

    initial begin
        n_total = 0;
        n_bad   = 0;
        trst    = 1'b0;
        a_if.select = 1'b0; a_if.captureDR = 1'b0; a_if.shiftDR = 1'b0;
        a_if.updateDR = 1'b0; a_if.tdi = 1'b0; a_if.capture_in = 8'h00;
        b_if.select = 1'b0; b_if.captureDR = 1'b0; b_if.shiftDR = 1'b0;
        b_if.updateDR = 1'b0; b_if.tdi = 1'b0; b_if.capture_in = 32'h0;
        tick();
        tick();

        // Reset values
        check_eq("rst_update_out", a_if.update_out, 8'h5A);
        check_eq("rst_tdo", a_if.tdo, 1'b0);
        check_eq("rst_count", a_if.shift_count, 4'd0);
        check_eq("rst_valid", a_if.update_valid, 1'b0);
        check_eq("rst_err", a_if.update_err, 1'b0);
        trst = 1'b1;
        tick();

        // Round trip: capture A5, shift in 3C, update
        a_if.select     = 1'b1;
        a_if.capture_in = 8'hA5;
        a_op(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("rt_cap_tdo", a_if.tdo, 1'b1);
        check_eq("rt_cap_count", a_if.shift_count, 4'd0);
        pat8 = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            got8[i] = a_if.tdo;
            a_op(1'b0, 1'b1, 1'b0, pat8[i]);
        end
        check_eq("rt_tdo_stream", got8, 8'hA5);
        check_eq("rt_count_full", a_if.shift_count, 4'd8);
        check_eq("rt_pre_update_out", a_if.update_out, 8'h5A);
        a_op(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("rt_update_out", a_if.update_out, 8'h3C);
        check_eq("rt_valid_hi", a_if.update_valid, 1'b1);
        tick();
        check_eq("rt_valid_lo", a_if.update_valid, 1'b0);

        // Deselected: enables toggle but nothing changes
        a_if.select     = 1'b0;
        a_if.capture_in = 8'hFF;
        a_op(1'b1, 1'b0, 1'b0, 1'b1);
        a_op(1'b0, 1'b1, 1'b0, 1'b1);
        a_op(1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("desel_valid", a_if.update_valid, 1'b0);
        a_op(1'b1, 1'b1, 1'b1, 1'b1);
        check_eq("desel_update_out", a_if.update_out, 8'h3C);
        check_eq("desel_count", a_if.shift_count, 4'd8);
        check_eq("desel_valid2", a_if.update_valid, 1'b0);
        a_if.select = 1'b1;
        for (int i = 0; i < 8; i++) begin
            got8[i] = a_if.tdo;
            a_op(1'b0, 1'b1, 1'b0, 1'b0);
        end
        check_eq("desel_shift_reg", got8, 8'h3C);
        check_eq("sat_count", a_if.shift_count, 4'd8);

        // Enable priority
        a_if.capture_in = 8'h81;
        a_op(1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("prio_cap_count", a_if.shift_count, 4'd0);
        check_eq("prio_cap_tdo", a_if.tdo, 1'b1);
        a_op(1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("prio_cap_upd_out", a_if.update_out, 8'h3C);
        check_eq("prio_cap_upd_valid", a_if.update_valid, 1'b0);
        a_op(1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("prio_sh_count", a_if.shift_count, 4'd1);
        check_eq("prio_sh_tdo", a_if.tdo, 1'b0);
        check_eq("prio_sh_upd_out", a_if.update_out, 8'h3C);
        check_eq("prio_sh_valid", a_if.update_valid, 1'b0);

        // Asynchronous reset mid-shift, then an update edge held in reset
        a_if.capture_in = 8'hA5;
        a_op(1'b1, 1'b0, 1'b0, 1'b0);
        a_op(1'b0, 1'b1, 1'b0, 1'b1);
        a_op(1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("mid_pre_tdo", a_if.tdo, 1'b1);
        check_eq("mid_pre_count", a_if.shift_count, 4'd2);
        #2;
        trst = 1'b0;
        #1;
        check_eq("mid_rst_tdo", a_if.tdo, 1'b0);
        check_eq("mid_rst_count", a_if.shift_count, 4'd0);
        check_eq("mid_rst_update_out", a_if.update_out, 8'h5A);
        a_op(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("mid_upd_out", a_if.update_out, 8'h5A);
        check_eq("mid_upd_valid", a_if.update_valid, 1'b0);
        trst = 1'b1;
        tick();

        // Short scan then update: behaviour depends on the length check
        a_if.capture_in = 8'h0F;
        a_op(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            a_op(1'b0, 1'b1, 1'b0, 1'b1);
        end
        check_eq("short_count", a_if.shift_count, 4'd5);
        a_op(1'b0, 1'b0, 1'b1, 1'b0);
`ifdef JTAG_TDR_LENGTH_CHECK_EN
        exp_upd = 8'h5A; exp_valid = 1'b0; exp_err = 1'b1;
`else
        exp_upd = 8'hF8; exp_valid = 1'b1; exp_err = 1'b0;
`endif
        check_eq("short_update_out", a_if.update_out, exp_upd);
        check_eq("short_valid", a_if.update_valid, exp_valid);
        check_eq("short_err", a_if.update_err, exp_err);
        tick();
        check_eq("short_err_sticky", a_if.update_err, exp_err);
        a_op(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("cap_clears_err", a_if.update_err, 1'b0);
        pat12 = 12'hC96;
        for (int i = 0; i < 12; i++) begin
            a_op(1'b0, 1'b1, 1'b0, pat12[i]);
        end
        check_eq("long_count", a_if.shift_count, 4'd8);
        a_op(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("long_update_out", a_if.update_out, 8'hC9);
        check_eq("long_valid", a_if.update_valid, 1'b1);
        check_eq("long_err", a_if.update_err, 1'b0);
        a_if.select = 1'b0;

        // IDCODE instance: constant capture with forced LSB
        b_if.select    = 1'b1;
        b_if.captureDR = 1'b1;
        tick();
        b_if.captureDR = 1'b0;
        check_eq("id_cap_tdo", b_if.tdo, 1'b1);
        check_eq("id_cap_count", b_if.shift_count, 6'd0);
        b_if.shiftDR = 1'b1;
        b_if.tdi     = 1'b0;
        for (int i = 0; i < 32; i++) begin
            got32[i] = b_if.tdo;
            tick();
        end
        b_if.shiftDR = 1'b0;
        check_eq("id_tdo_stream", got32, 32'h1234_5679);
        check_eq("id_count", b_if.shift_count, 6'd32);
        check_eq("id_update_out", b_if.update_out, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
